// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin request arbiter and its encoder.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int ARB_OUT_SIZE_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest pending index at or above ptr,
// wrapping to the lowest index below ptr when nothing qualifies.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int OUT_SIZE = ARB_OUT_SIZE_DEF,
    localparam int IN_SIZE  = 1 << OUT_SIZE
) (
    input  logic [IN_SIZE-1:0]  pending,
    input  logic [OUT_SIZE-1:0] ptr,
    output logic [IN_SIZE-1:0]  pick,
    output logic [OUT_SIZE-1:0] pick_idx,
    output logic                any
);

    // Scanning ptr, ptr+1, ... with natural OUT_SIZE-bit overflow covers the wrap for free.
    always_comb begin
        logic [OUT_SIZE-1:0] cand;
        cand     = '0;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int i = 0; i < IN_SIZE; i++) begin
            cand = ptr + OUT_SIZE'(i);
            if (!any && pending[cand]) begin
                any      = 1'b1;
                pick_idx = cand;
            end
        end
        if (any) begin
            pick[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Sticky request capture with round-robin one-hot grant and ready/valid handshake.
// Optional sticky duplicate-request flag enabled by defining ARB_OVF_EN.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter  int OUT_SIZE = ARB_OUT_SIZE_DEF,
    localparam int IN_SIZE  = 1 << OUT_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_SIZE-1:0] req_in,
    output logic [IN_SIZE-1:0] grant,
    output logic               grant_valid,
    input  logic               grant_ready,
    output logic [IN_SIZE-1:0] pending
`ifdef ARB_OVF_EN
    ,
    input  logic               ovf_clr,
    output logic               ovf
`endif
);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [OUT_SIZE-1:0] ptr;
    logic [OUT_SIZE-1:0] ptr_next;
    logic [OUT_SIZE-1:0] idx;
    logic [OUT_SIZE-1:0] idx_next;
    logic [IN_SIZE-1:0]  grant_next;
    logic                valid_next;
    logic [IN_SIZE-1:0]  pick;
    logic [OUT_SIZE-1:0] pick_idx;
    logic                pick_any;
    logic                handshake;
    logic [IN_SIZE-1:0]  clear_mask;
    logic [IN_SIZE-1:0]  pending_next;

    rr_pick #(
        .OUT_SIZE (OUT_SIZE)
    ) u_pick (
        .pending  (pending),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // A new request on the bit being acked wins over the clear.
    assign handshake    = grant_valid & grant_ready;
    assign clear_mask   = handshake ? grant : '0;
    assign pending_next = (pending & ~clear_mask) | req_in;

    always_comb begin
        state_next = state;
        grant_next = grant;
        idx_next   = idx;
        valid_next = grant_valid;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick;
                    idx_next   = pick_idx;
                    valid_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    ptr_next   = idx + OUT_SIZE'(1);
                    grant_next = '0;
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            pending     <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            idx         <= idx_next;
            grant       <= grant_next;
            grant_valid <= valid_next;
            pending     <= pending_next;
        end
    end

`ifdef ARB_OVF_EN
    // Flags a request landing on a bit that is already pending and not being acked.
    logic ovf_set;
    assign ovf_set = |(req_in & pending & ~clear_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter; covers the ovf flag when ARB_OVF_EN is defined.
module tb_rr_req_arbiter;

    localparam int OUT_SIZE = 4;
    localparam int IN_SIZE  = 1 << OUT_SIZE;

    logic               clk;
    logic               rst_n;
    logic [IN_SIZE-1:0] req_in;
    logic [IN_SIZE-1:0] grant;
    logic               grant_valid;
    logic               grant_ready;
    logic [IN_SIZE-1:0] pending;
`ifdef ARB_OVF_EN
    logic               ovf_clr;
    logic               ovf;
`endif

    int n_checks;
    int n_fails;

    rr_req_arbiter #(
        .OUT_SIZE (OUT_SIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .pending     (pending)
`ifdef ARB_OVF_EN
        ,
        .ovf_clr     (ovf_clr),
        .ovf         (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n       = 1'b0;
        req_in      = '0;
        grant_ready = 1'b0;
`ifdef ARB_OVF_EN
        ovf_clr     = 1'b0;
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b1;
        req_in      = '0;
        grant_ready = 1'b0;
`ifdef ARB_OVF_EN
        ovf_clr     = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, grant_valid, pending} !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_assert: grant=%h valid=%b pending=%h, required all zero", grant, grant_valid, pending);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({grant, grant_valid, pending} !== '0) begin
                n_fails++;
                $display("[TB] FAIL reset_idle cycle %0d: grant=%h valid=%b pending=%h, required all zero", c, grant, grant_valid, pending);
            end
        end
    endtask

    task automatic test_single_latency();
        logic [15:0] exp_grant [4] = '{16'h0040, 16'h0000, 16'h0010, 16'h0000};
        logic        exp_valid [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        applyReset();
        req_in      = 16'h0010;
        grant_ready = 1'b1;
        step();
        req_in = '0;
        n_checks++;
        if (pending !== 16'h0010 || grant_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL latency_capture: pending=%h valid=%b, required 0010 0", pending, grant_valid);
        end
        step();
        n_checks++;
        if (grant !== 16'h0010 || grant_valid !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL latency_grant: grant=%h valid=%b, required 0010 1", grant, grant_valid);
        end
        step();
        n_checks++;
        if ({grant, grant_valid, pending} !== '0) begin
            n_fails++;
            $display("[TB] FAIL latency_ack: grant=%h valid=%b pending=%h, required all zero", grant, grant_valid, pending);
        end
        // ptr is now 5: bit 6 must beat bit 4, then bit 4 via wrap.
        req_in = 16'h0050;
        step();
        req_in = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (grant !== exp_grant[c] || grant_valid !== exp_valid[c]) begin
                n_fails++;
                $display("[TB] FAIL ptr_after_ack step %0d: grant=%h valid=%b, required %h %b", c, grant, grant_valid, exp_grant[c], exp_valid[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] order [6] = '{16'h0001, 16'h0020, 16'h0400, 16'h8000, 16'h0001, 16'h8000};
        applyReset();
        grant_ready = 1'b1;
        req_in      = 16'h8421;
        step();
        req_in = '0;
        for (int g = 0; g < 6; g++) begin
            if (g == 4) begin
                req_in = 16'h8001;
                step();
                req_in = '0;
            end
            step();
            n_checks++;
            if (grant !== order[g] || grant_valid !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL rr_order %0d: grant=%h valid=%b, required %h 1", g, grant, grant_valid, order[g]);
            end
            step();
            n_checks++;
            if (grant_valid !== 1'b0 || grant !== 16'h0000) begin
                n_fails++;
                $display("[TB] FAIL rr_gap %0d: grant=%h valid=%b, required 0000 0", g, grant, grant_valid);
            end
        end
        n_checks++;
        if (pending !== 16'h0000) begin
            n_fails++;
            $display("[TB] FAIL rr_drained: pending=%h, required 0000", pending);
        end
    endtask

    task automatic test_backpressure();
        applyReset();
        req_in = 16'h0004;
        step();
        req_in = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            req_in = (c == 1) ? 16'h0001 : 16'h0000;
            step();
            n_checks++;
            if (grant !== 16'h0004 || grant_valid !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL bp_hold cycle %0d: grant=%h valid=%b, required 0004 1", c, grant, grant_valid);
            end
        end
        req_in = '0;
        n_checks++;
        if (pending !== 16'h0005) begin
            n_fails++;
            $display("[TB] FAIL bp_pending: pending=%h, required 0005", pending);
        end
        grant_ready = 1'b1;
        step();
        n_checks++;
        if (grant_valid !== 1'b0 || pending !== 16'h0001) begin
            n_fails++;
            $display("[TB] FAIL bp_ack: valid=%b pending=%h, required 0 0001", grant_valid, pending);
        end
        step();
        n_checks++;
        if (grant !== 16'h0001 || grant_valid !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL bp_wrap: grant=%h valid=%b, required 0001 1", grant, grant_valid);
        end
        step();
        grant_ready = 1'b0;
    endtask

    task automatic test_collision();
        logic [15:0] exp_grant [4] = '{16'h0020, 16'h0000, 16'h0004, 16'h0000};
        applyReset();
        req_in = 16'h0004;
        step();
        req_in = '0;
        step();
        grant_ready = 1'b1;
        req_in      = 16'h0024;
        step();
        req_in = '0;
        n_checks++;
        if (pending !== 16'h0024 || grant_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL collision_set_wins: pending=%h valid=%b, required 0024 0", pending, grant_valid);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (grant !== exp_grant[c]) begin
                n_fails++;
                $display("[TB] FAIL collision_regrant step %0d: grant=%h, required %h", c, grant, exp_grant[c]);
            end
        end
        n_checks++;
        if (pending !== 16'h0000) begin
            n_fails++;
            $display("[TB] FAIL collision_drained: pending=%h, required 0000", pending);
        end
        grant_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        applyReset();
        req_in = 16'h0100;
        step();
        req_in = 16'h0200;
        step();
        req_in = '0;
        n_checks++;
        if (grant !== 16'h0100 || grant_valid !== 1'b1 || pending !== 16'h0300) begin
            n_fails++;
            $display("[TB] FAIL async_setup: grant=%h valid=%b pending=%h, required 0100 1 0300", grant, grant_valid, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, grant_valid, pending} !== '0) begin
            n_fails++;
            $display("[TB] FAIL async_reset: grant=%h valid=%b pending=%h, required all zero", grant, grant_valid, pending);
        end
        step();
        rst_n = 1'b1;
    endtask

`ifdef ARB_OVF_EN
    task automatic test_overflow();
        logic [15:0] reqs  [6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
        logic        clrs  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        rdys  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_o [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        applyReset();
        for (int c = 0; c < 6; c++) begin
            req_in      = reqs[c];
            ovf_clr     = clrs[c];
            grant_ready = rdys[c];
            step();
            n_checks++;
            if (ovf !== exp_o[c]) begin
                n_fails++;
                $display("[TB] FAIL ovf step %0d: ovf=%b, required %b", c, ovf, exp_o[c]);
            end
        end
        n_checks++;
        if (pending !== 16'h0001) begin
            n_fails++;
            $display("[TB] FAIL ovf_ack_pending: pending=%h, required 0001", pending);
        end
        req_in      = '0;
        ovf_clr     = 1'b0;
        grant_ready = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_async_reset();
`ifdef ARB_OVF_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Upstream stage of the one-hot-to-binary encoder. Captures single-cycle request pulses into a sticky pending register.
- Selects one pending request per transaction using round-robin priority. Presents the selection as a registered one-hot grant plus a valid flag; the flag drives the encoder enable.
- The downstream consumer accepts each grant with a ready/valid handshake.

Parameters:
- OUT_SIZE, 4, width of the encoded index.
- IN_SIZE, 1<<OUT_SIZE, number of request lines. Local, not overridable.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_in  input  IN_SIZE  request pulses; a 1 on bit i in any cycle sets pending[i].
- grant  output  IN_SIZE  one-hot grant; all zeros when grant_valid=0. Feeds the encoder input.
- grant_valid  output  1  grant is meaningful. Feeds the encoder enable.
- grant_ready  input  1  consumer accepts the grant this cycle.
- pending  output  IN_SIZE  current sticky request register, for status.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, takes effect immediately, even mid-transaction):
  - pending=0, grant=0, grant_valid=0.
  - Round-robin pointer ptr=0, internal index idx=0, state=IDLE.
- Request capture: at each rising edge, pending <= (pending & ~clear_mask) | req_in.
  - clear_mask is the one-hot of the granted bit on a handshake cycle, else 0.
  - Set has priority over clear: a new req on the bit being acked in the same cycle leaves that bit pending.
- State machine, two states:
  - IDLE: if pending != 0 at an edge, latch the selected bit into grant/idx, set grant_valid=1, go to GRANT. Otherwise stay.
  - Selection uses the registered pending value, not req_in. Latency: req pulse sampled at edge k, grant_valid=1 after edge k+1.
  - GRANT: grant and idx are held stable while grant_ready=0. A request on another bit never changes an outstanding grant.
  - Handshake (grant_valid & grant_ready): clear pending[idx], set ptr <= (idx+1) mod IN_SIZE, go to IDLE, drop grant_valid and grant to 0.
  - Minimum spacing is one idle cycle between grants, so at most one grant per 2 cycles.
- Round-robin selection:
  - Pick the lowest pending index at or above ptr.
  - If none, wrap and pick the lowest pending index below ptr.
  - ptr wraps from IN_SIZE-1 to 0 (OUT_SIZE-bit natural overflow).
- Every bit, including IN_SIZE-1, is grantable.
- grant is always one-hot or zero, never multi-hot.
- grant_ready while grant_valid=0 is ignored.

Optional Feature:
- Macro ARB_OVF_EN. When defined, adds two ports:
  - ovf_clr  input  1  clears ovf.
  - ovf  output  1  sticky overflow flag.
- ovf sets when req_in[i]=1 while pending[i]=1 and bit i is not being cleared that cycle.
- ovf clears on ovf_clr. If set and clear occur together, set wins. Reset value 0.
- When ARB_OVF_EN is undefined, these ports and that logic do not exist. Duplicate requests merge silently.

Decomposition:
- Package arb_pkg holds:
  - typedef enum {IDLE, GRANT} arb_state_t;
  - constant ARB_OUT_SIZE_DEF=4, the shared default for this block and the encoder.
- Sub-module rr_pick: combinational.
  - Inputs: pending vector and ptr.
  - Outputs: one-hot pick, binary index, and any flag.
  - Instantiated once.

Test Plan:
- Reset behaviour: reset released, no requests for 10 cycles -> grant=0, grant_valid=0, pending=0 throughout.
- Single request latency: req_in=16'h0010 for one cycle at edge k, grant_ready=1 -> grant_valid=1, grant=16'h0010 after edge k+1. Handshake at the next edge; pending=0, ptr=5.
- Round-robin fairness: pending=16'h8421 with ptr=0, grant_ready held 1 -> grants in order 0x0001, 0x0020, 0x0400, 0x8000, then 0x0001 again once re-requested. Bit 15 must be granted.
- Backpressure: grant 0x0004 outstanding, grant_ready=0 for 5 cycles, req_in=0x0001 pulsed -> grant stays 0x0004. After ready, next grant is 0x0001 (wrap from ptr=3).
- Set/clear collision: ack of bit 2 and req_in=0x0004 in the same cycle -> pending[2] stays 1. Bit 2 is granted again once no other bit is pending.
- Async reset mid-grant: assert rst_n=0 while grant_valid=1, between clock edges -> grant, grant_valid and pending go to 0 immediately, before the next edge. With ARB_OVF_EN, a duplicate request on a pending bit sets ovf=1, and ovf_clr clears it.
